// File: rtl/light_house_ootx_pkg.sv
// ---------------------------------------------------------------------------
// light_house_ootx_pkg
// Shared types and constants for the lighthouse OOTX frame receiver:
//   ootx_state_t   framing FSM states
//   PREAMBLE_ZEROS zero bits that, followed by a 1, mark a frame start
//   WORD_BITS      data bits per word (each word is followed by one sync bit)
//   CRC_WORDS      trailing CRC words per frame
//   payload_words  byte length -> payload word count, ceil(L/2)
// ---------------------------------------------------------------------------
package light_house_ootx_pkg;

    localparam int PREAMBLE_ZEROS = 17;
    localparam int WORD_BITS      = 16;
    localparam int CRC_WORDS      = 2;
    localparam int ADDR_BITS      = 8;

    // Wide enough to hold 0..PREAMBLE_ZEROS and 0..WORD_BITS.
    localparam int ZCNT_BITS   = 5;
    localparam int BITCNT_BITS = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LENGTH,
        ST_PAYLOAD,
        ST_CRC
    } ootx_state_t;

    // ceil(len/2) without overflow: the add is done one bit wider.
    function automatic word_t payload_words(input word_t len);
        logic [WORD_BITS:0] sum;
        sum = {1'b0, len} + {{WORD_BITS{1'b0}}, 1'b1};
        return sum[WORD_BITS:1];
    endfunction

endpackage

// File: rtl/light_house_ootx_if.sv
// ---------------------------------------------------------------------------
// light_house_ootx_if
// Serial input and word-strobe output bundle of the OOTX receiver.
//   DATA_IN   serial data bit, stable around each DCLK rising edge
//   DCLK      bit clock, asynchronous to the system clock
//   DATA_OUT  last received word, first received bit in the MSB
//   ADDRESS   word index of DATA_OUT within its frame
//   READY     one-cycle strobe; DATA_OUT/ADDRESS valid while high
// master: the bit source (drives DATA_IN/DCLK); slave: the receiver.
// ---------------------------------------------------------------------------
interface light_house_ootx_if;
    import light_house_ootx_pkg::*;

    logic  DATA_IN;
    logic  DCLK;
    word_t DATA_OUT;
    addr_t ADDRESS;
    logic  READY;

    modport master (
        output DATA_IN,
        output DCLK,
        input  DATA_OUT,
        input  ADDRESS,
        input  READY
    );

    modport slave (
        input  DATA_IN,
        input  DCLK,
        output DATA_OUT,
        output ADDRESS,
        output READY
    );

endinterface

// File: rtl/light_house_ootx_bit_sync.sv
// ---------------------------------------------------------------------------
// ootx_bit_sync
// Brings DCLK and DATA_IN into the clk_i domain and turns each DCLK rising
// edge into a single-cycle bit_valid_o pulse carrying bit_value_o.
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   dclk_i       raw bit clock
//   data_i       raw serial data
//   bit_valid_o  one-cycle pulse per synchronised DCLK rising edge
//   bit_value_o  synchronised data bit, valid with bit_valid_o
// ---------------------------------------------------------------------------
module ootx_bit_sync #(
    parameter int SYNC_STAGES = 2   // legal range 2..3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dclk_i,
    input  logic data_i,
    output logic bit_valid_o,
    output logic bit_value_o
);

    logic [SYNC_STAGES-1:0] dclk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   dclk_prev_q;
    logic                   armed_q;

    logic dclk_s;
    logic data_s;

    assign dclk_s = dclk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dclk_sync_q <= '0;
            data_sync_q <= '0;
            dclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], dclk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_i};
            dclk_prev_q <= dclk_s;
            // Edges are accepted only after DCLK has been seen low once, so a
            // DCLK already high at reset release does not look like a new bit.
            if (!dclk_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Data travels through the same number of stages as DCLK, so it is
    // aligned with the detected edge.
    assign bit_valid_o = armed_q & dclk_s & ~dclk_prev_q;
    assign bit_value_o = data_s;

endmodule

// File: rtl/light_house_ootx.sv
// ---------------------------------------------------------------------------
// light_house_ootx
// Lighthouse OOTX frame receiver. Hunts for the preamble (17 zeros then a 1),
// then collects 16-bit words each followed by a sync bit: one length word,
// ceil(L/2) payload words and two CRC words. Every word with sync = 1 is
// strobed out with its index in the frame; sync = 0 abandons the frame.
//   CLK    system clock
//   RESET  asynchronous active-high reset
//   bus    slave side of light_house_ootx_if (DATA_IN, DCLK in;
//          DATA_OUT, ADDRESS, READY out)
// ---------------------------------------------------------------------------
module light_house_ootx
    import light_house_ootx_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal range 2..3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    light_house_ootx_if.slave     bus
);

    localparam logic [ZCNT_BITS-1:0]   ZCNT_MAX    = ZCNT_BITS'(PREAMBLE_ZEROS);
    localparam logic [BITCNT_BITS-1:0] BITCNT_SYNC = BITCNT_BITS'(WORD_BITS);
    localparam word_t                  CRC_COUNT   = WORD_BITS'(CRC_WORDS);

    logic bit_valid;
    logic bit_value;

    ootx_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bit_sync (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .dclk_i      (bus.DCLK),
        .data_i      (bus.DATA_IN),
        .bit_valid_o (bit_valid),
        .bit_value_o (bit_value)
    );

    ootx_state_t            state_q,  state_d;
    logic [ZCNT_BITS-1:0]   zcnt_q,   zcnt_d;    // consecutive zero bits, saturating
    word_t                  shift_q,  shift_d;   // word being assembled
    logic [BITCNT_BITS-1:0] bitcnt_q, bitcnt_d;  // bits of the current word seen
    addr_t                  widx_q,   widx_d;    // index of the word in progress
    word_t                  rem_q,    rem_d;     // words left in PAYLOAD / CRC
    word_t                  data_q,   data_d;
    addr_t                  addr_q,   addr_d;
    logic                   ready_q,  ready_d;

    word_t payload_n;
    assign payload_n = payload_words(shift_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_HUNT;
            zcnt_q   <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            widx_q   <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            zcnt_q   <= zcnt_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            widx_q   <= widx_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        zcnt_d   = zcnt_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        widx_d   = widx_q;
        rem_d    = rem_q;
        data_d   = data_q;
        addr_d   = addr_q;
        ready_d  = 1'b0;

        if (bit_valid) begin
            // The zero run is tracked in every state, including inside words.
            if (bit_value) begin
                zcnt_d = '0;
            end else if (zcnt_q != ZCNT_MAX) begin
                zcnt_d = zcnt_q + 1'b1;
            end

            if (bit_value && (zcnt_q == ZCNT_MAX)) begin
                // Preamble wins from any state and restarts the frame.
                state_d  = ST_LENGTH;
                shift_d  = '0;
                bitcnt_d = '0;
                widx_d   = '0;
            end else if (state_q != ST_HUNT) begin
                if (bitcnt_q != BITCNT_SYNC) begin
                    shift_d  = {shift_q[WORD_BITS-2:0], bit_value};
                    bitcnt_d = bitcnt_q + 1'b1;
                end else begin
                    // This bit is the sync bit closing the word.
                    bitcnt_d = '0;
                    if (!bit_value) begin
                        state_d = ST_HUNT;
                    end else begin
                        ready_d = 1'b1;
                        data_d  = shift_q;
                        addr_d  = widx_q;
                        widx_d  = widx_q + 1'b1;
                        case (state_q)
                            ST_LENGTH: begin
                                if (payload_n != '0) begin
                                    state_d = ST_PAYLOAD;
                                    rem_d   = payload_n;
                                end else begin
                                    state_d = ST_CRC;
                                    rem_d   = CRC_COUNT;
                                end
                            end
                            ST_PAYLOAD: begin
                                if (rem_q == word_t'(1)) begin
                                    state_d = ST_CRC;
                                    rem_d   = CRC_COUNT;
                                end else begin
                                    rem_d = rem_q - 1'b1;
                                end
                            end
                            ST_CRC: begin
                                if (rem_q == word_t'(1)) begin
                                    state_d = ST_HUNT;
                                end else begin
                                    rem_d = rem_q - 1'b1;
                                end
                            end
                            default: begin
                                state_d = ST_HUNT;
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign bus.DATA_OUT = data_q;
    assign bus.ADDRESS  = addr_q;
    assign bus.READY    = ready_q;

endmodule

// File: tb/tb_light_house_ootx.sv
// ---------------------------------------------------------------------------
// tb_light_house_ootx
// Directed bench for light_house_ootx: drives OOTX bit streams through the
// interface, records every READY strobe and compares against hand-computed
// word/address lists.
// ---------------------------------------------------------------------------
module tb_light_house_ootx;

    logic CLK;
    logic RESET;

    light_house_ootx_if bus ();

    light_house_ootx #(
        .SYNC_STAGES (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Strobe capture
    logic [15:0] cap_d[$];
    logic [7:0]  cap_a[$];
    logic [15:0] exp_q[$];
    logic        prev_ready = 1'b0;
    logic        long_pulse = 1'b0;

    always @(negedge CLK) begin
        if (bus.READY === 1'b1) begin
            if (prev_ready) begin
                long_pulse = 1'b1;
            end else begin
                cap_d.push_back(bus.DATA_OUT);
                cap_a.push_back(bus.ADDRESS);
            end
        end
        prev_ready = (bus.READY === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares captured strobes with exp_q; addresses must run 0,1,2,...
    task automatic expect_strobes(input string tag);
        check({tag, "_count"}, cap_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_d.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), {24'd0, cap_a[i]}, i);
            check($sformatf("%s_data%0d", tag, i), {16'd0, cap_d[i]}, {16'd0, exp_q[i]});
        end
        cap_d.delete();
        cap_a.delete();
        exp_q.delete();
    endtask

    // One bit: DCLK low >= 4 CLK, high 5 CLK, data set up before the edge.
    task automatic send_bit(input logic b);
        @(negedge CLK);
        bus.DATA_IN = b;
        repeat (2) @(negedge CLK);
        bus.DCLK = 1'b1;
        repeat (5) @(negedge CLK);
        bus.DCLK = 1'b0;
        repeat (5) @(negedge CLK);
    endtask

    task automatic send_word(input logic [15:0] w, input logic s);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i]);
        end
        send_bit(s);
    endtask

    task automatic send_preamble();
        repeat (17) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    initial begin
        RESET       = 1'b1;
        bus.DCLK    = 1'b0;
        bus.DATA_IN = 1'b0;
        repeat (4) @(negedge CLK);

        // Reset state
        check("rst_data",  {16'd0, bus.DATA_OUT}, 32'd0);
        check("rst_addr",  {24'd0, bus.ADDRESS},  32'd0);
        check("rst_ready", {31'd0, bus.READY},    32'd0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        // Mixed stream: ABCD/0 then 0000/1 forms the preamble; length 14
        // gives 7 payload + 2 CRC words; 3210 falls into HUNT.
        send_word(16'hABCD, 1'b0);
        send_word(16'h0000, 1'b1);
        send_word(16'h000E, 1'b1);
        send_word(16'h0123, 1'b1);
        send_word(16'h4567, 1'b1);
        send_word(16'h89AB, 1'b1);
        repeat (40) @(negedge CLK);   // idle gap, DCLK held low
        send_word(16'hCD00, 1'b1);
        send_word(16'h0000, 1'b1);
        send_word(16'h000E, 1'b1);
        send_word(16'hFEDC, 1'b1);
        send_word(16'hBA98, 1'b1);
        send_word(16'h7654, 1'b1);
        send_word(16'h3210, 1'b1);
        exp_q = {16'h000E, 16'h0123, 16'h4567, 16'h89AB, 16'hCD00,
                 16'h0000, 16'h000E, 16'hFEDC, 16'hBA98, 16'h7654};
        expect_strobes("stream");

        // Odd length 3 -> 2 payload words, 2 CRC, then HUNT
        send_preamble();
        send_word(16'h0003, 1'b1);
        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b1);
        send_word(16'hAAAA, 1'b1);
        send_word(16'hBBBB, 1'b1);
        send_word(16'h7777, 1'b1);
        exp_q = {16'h0003, 16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB};
        expect_strobes("len3");
        check("hold_data", {16'd0, bus.DATA_OUT}, 32'h0000BBBB);
        check("hold_addr", {24'd0, bus.ADDRESS},  32'd4);

        // Zero length: length word then straight to two CRC words
        send_preamble();
        send_word(16'h0000, 1'b1);
        send_word(16'hCAFE, 1'b1);
        send_word(16'hBEEF, 1'b1);
        send_word(16'h1357, 1'b1);
        exp_q = {16'h0000, 16'hCAFE, 16'hBEEF};
        expect_strobes("len0");

        // Payload word with sync 0 aborts the frame
        send_preamble();
        send_word(16'h0004, 1'b1);
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b1);
        send_word(16'h9ABC, 1'b1);
        exp_q = {16'h0004};
        expect_strobes("abort");

        // Sixteen zeros + 1 is not a preamble; seventeen is
        repeat (16) send_bit(1'b0);
        send_bit(1'b1);
        send_word(16'h5555, 1'b1);
        exp_q = {};
        expect_strobes("pre16");
        send_preamble();
        send_word(16'h0002, 1'b1);
        exp_q = {16'h0002};
        expect_strobes("pre17");

        // Reset in the middle of a payload
        send_preamble();
        send_word(16'h0008, 1'b1);
        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b1);
        send_word(16'h3333, 1'b1);
        exp_q = {16'h0008, 16'h1111, 16'h2222, 16'h3333};
        expect_strobes("prerst");
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("midrst_data",  {16'd0, bus.DATA_OUT}, 32'd0);
        check("midrst_addr",  {24'd0, bus.ADDRESS},  32'd0);
        check("midrst_ready", {31'd0, bus.READY},    32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        send_word(16'h4444, 1'b1);
        send_word(16'h5555, 1'b1);
        send_word(16'h6666, 1'b1);
        exp_q = {};
        expect_strobes("postrst");
        send_preamble();
        send_word(16'h0001, 1'b1);
        exp_q = {16'h0001};
        expect_strobes("recover");

        check("ready_one_cycle", {31'd0, long_pulse}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
